// File: rtl/l2cache_req_arbiter_if.sv
// Signal bundle between the four L2 requesters, the writeback snoop and the
// L2 request port. The arbiter connects through the slave modport; the
// requesters and the L2 model drive the master side.
interface l2cache_req_arbiter_if;
  // pipeline cache-op
  logic        op_req;
  logic [31:0] op_addr;
  logic [31:0] op_code;
  logic        op_ack;
  // Icache
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_addrOK;
  logic        i_dataOK;
  // Dcache
  logic        d_req;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [1:0]  d_size;
  logic        d_addrOK;
  logic        d_dataOK;
  // L2 prefetcher
  logic        p_req;
  logic [31:0] p_addr;
  logic        p_addrOK;
  logic        p_done;
  // writeback snoop
  logic        wb_busy;
  logic [31:0] wb_addr;
  // L2 request port
  logic        l2_req;
  logic [2:0]  l2_from;
  logic [31:0] l2_addr;
  logic [31:0] l2_opcode;
  logic [31:0] l2_wdata;
  logic [3:0]  l2_wstrb;
  logic [1:0]  l2_size;
  logic        l2_addrOK;
  logic        l2_dataOK;

  modport slave (
    input  op_req, op_addr, op_code,
    output op_ack,
    input  i_req, i_addr,
    output i_addrOK, i_dataOK,
    input  d_req, d_wr, d_addr, d_wdata, d_wstrb, d_size,
    output d_addrOK, d_dataOK,
    input  p_req, p_addr,
    output p_addrOK, p_done,
    input  wb_busy, wb_addr,
    output l2_req, l2_from, l2_addr, l2_opcode, l2_wdata, l2_wstrb, l2_size,
    input  l2_addrOK, l2_dataOK
  );

  modport master (
    output op_req, op_addr, op_code,
    input  op_ack,
    output i_req, i_addr,
    input  i_addrOK, i_dataOK,
    output d_req, d_wr, d_addr, d_wdata, d_wstrb, d_size,
    input  d_addrOK, d_dataOK,
    output p_req, p_addr,
    input  p_addrOK, p_done,
    output wb_busy, wb_addr,
    input  l2_req, l2_from, l2_addr, l2_opcode, l2_wdata, l2_wstrb, l2_size,
    output l2_addrOK, l2_dataOK
  );
endinterface

// File: rtl/l2cache_req_arbiter.sv
// l2cache_req_arbiter: single-outstanding arbiter in front of the L2 request
// port. Grants one of cache-op / Dcache / Icache / prefetcher (fixed priority
// op > D > I > pref), latches the winner's payload, runs the L2 handshake and
// routes the completion back to the owner. Dcache writes to the line under
// writeback are held off.
// Optional build macro L2ARB_STARVE_GUARD_EN: an Icache age counter promotes a
// starved Icache above the Dcache once it has waited STARVE_LIMIT cycles.
module l2cache_req_arbiter #(
  parameter int LINE_OFF_W   = 5,
  parameter int STARVE_LIMIT = 8,
  parameter int AGE_W        = 4
) (
  input logic                  clk,
  input logic                  rstn,
  l2cache_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] FROM_OP = 3'd0;
  localparam logic [2:0] FROM_I  = 3'd1;
  localparam logic [2:0] FROM_DR = 3'd2;
  localparam logic [2:0] FROM_DW = 3'd3;
  localparam logic [2:0] FROM_PF = 3'd4;

  state_t      state_r, state_s;
  logic        take_s;
  logic [2:0]  win_s;
  logic [31:0] nxt_addr_s, nxt_opcode_s, nxt_wdata_s;
  logic [3:0]  nxt_wstrb_s;
  logic [1:0]  nxt_size_s;

  logic        l2_req_r;
  logic [2:0]  l2_from_r;
  logic [31:0] l2_addr_r, l2_opcode_r, l2_wdata_r;
  logic [3:0]  l2_wstrb_r;
  logic [1:0]  l2_size_r;
  logic        i_addrok_r, d_addrok_r, p_addrok_r;

  logic        d_blk_s;
  logic        i_promote_s;
  logic        done_s;
  logic        unused_s;

  // Dcache write to the line currently leaving for memory must wait.
  assign d_blk_s = bus.d_req & bus.d_wr & bus.wb_busy &
                   (bus.d_addr[31:LINE_OFF_W] == bus.wb_addr[31:LINE_OFF_W]);

  // Line-offset bits of the writeback address take no part in the compare.
  assign unused_s = ^{bus.wb_addr[LINE_OFF_W-1:0], 32'(STARVE_LIMIT), 32'(AGE_W)};

`ifdef L2ARB_STARVE_GUARD_EN
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
  logic [AGE_W-1:0] age_r;
  logic             i_grant_s;
  logic             i_owner_s;

  assign i_grant_s   = take_s & (win_s == FROM_I);
  assign i_owner_s   = (state_r != ST_IDLE) & (l2_from_r == FROM_I);
  assign i_promote_s = ({{(32-AGE_W){1'b0}}, age_r} >= 32'(STARVE_LIMIT));

  // Icache wait age: saturating count of cycles the Icache is kept waiting.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      age_r <= {AGE_W{1'b0}};
    end else if (!bus.i_req || i_grant_s) begin
      age_r <= {AGE_W{1'b0}};
    end else if (i_owner_s) begin
      age_r <= age_r;
    end else if (age_r != AGE_MAX) begin
      age_r <= age_r + {{(AGE_W-1){1'b0}}, 1'b1};
    end else begin
      age_r <= age_r;
    end
  end
`else
  assign i_promote_s = 1'b0;
`endif

  // Winner selection and the payload it would latch; only acted on in IDLE.
  always_comb begin
    take_s       = 1'b0;
    win_s        = FROM_OP;
    nxt_addr_s   = 32'd0;
    nxt_opcode_s = 32'd0;
    nxt_wdata_s  = 32'd0;
    nxt_wstrb_s  = 4'd0;
    nxt_size_s   = 2'd2;
    if (bus.op_req) begin
      take_s       = 1'b1;
      win_s        = FROM_OP;
      nxt_addr_s   = bus.op_addr;
      nxt_opcode_s = bus.op_code;
    end else if (bus.i_req && i_promote_s) begin
      take_s     = 1'b1;
      win_s      = FROM_I;
      nxt_addr_s = bus.i_addr;
    end else if (bus.d_req && !d_blk_s) begin
      take_s     = 1'b1;
      win_s      = bus.d_wr ? FROM_DW : FROM_DR;
      nxt_addr_s = bus.d_addr;
      nxt_size_s = bus.d_size;
      if (bus.d_wr) begin
        nxt_wdata_s = bus.d_wdata;
        nxt_wstrb_s = bus.d_wstrb;
      end else begin
        nxt_wdata_s = 32'd0;
        nxt_wstrb_s = 4'd0;
      end
    end else if (bus.i_req) begin
      take_s     = 1'b1;
      win_s      = FROM_I;
      nxt_addr_s = bus.i_addr;
    end else if (bus.p_req && !bus.d_req) begin
      take_s     = 1'b1;
      win_s      = FROM_PF;
      nxt_addr_s = bus.p_addr;
    end else begin
      take_s = 1'b0;
    end
    if (state_r != ST_IDLE) begin
      take_s = 1'b0;
    end else begin
      take_s = take_s;
    end
  end

  // Next state of the IDLE -> REQ -> RESP -> IDLE transaction sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (take_s) state_s = ST_REQ;
        else        state_s = ST_IDLE;
      end
      ST_REQ: begin
        if (bus.l2_addrOK) state_s = ST_RESP;
        else               state_s = ST_REQ;
      end
      ST_RESP: begin
        if (bus.l2_dataOK) state_s = ST_IDLE;
        else               state_s = ST_RESP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Latched payload, L2 request valid and the one-cycle addrOK pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      l2_req_r    <= 1'b0;
      l2_from_r   <= 3'd0;
      l2_addr_r   <= 32'd0;
      l2_opcode_r <= 32'd0;
      l2_wdata_r  <= 32'd0;
      l2_wstrb_r  <= 4'd0;
      l2_size_r   <= 2'd0;
      i_addrok_r  <= 1'b0;
      d_addrok_r  <= 1'b0;
      p_addrok_r  <= 1'b0;
    end else begin
      i_addrok_r <= 1'b0;
      d_addrok_r <= 1'b0;
      p_addrok_r <= 1'b0;
      if (take_s) begin
        l2_req_r    <= 1'b1;
        l2_from_r   <= win_s;
        l2_addr_r   <= nxt_addr_s;
        l2_opcode_r <= nxt_opcode_s;
        l2_wdata_r  <= nxt_wdata_s;
        l2_wstrb_r  <= nxt_wstrb_s;
        l2_size_r   <= nxt_size_s;
        i_addrok_r  <= (win_s == FROM_I);
        d_addrok_r  <= (win_s == FROM_DR) | (win_s == FROM_DW);
        p_addrok_r  <= (win_s == FROM_PF);
      end else if (state_r == ST_REQ && bus.l2_addrOK) begin
        l2_req_r <= 1'b0;
      end else begin
        l2_req_r <= l2_req_r;
      end
    end
  end

  // Completion is routed to the owner in the same cycle as l2_dataOK.
  assign done_s = (state_r == ST_RESP) & bus.l2_dataOK;

  assign bus.op_ack    = done_s & (l2_from_r == FROM_OP);
  assign bus.i_dataOK  = done_s & (l2_from_r == FROM_I);
  assign bus.d_dataOK  = done_s & ((l2_from_r == FROM_DR) | (l2_from_r == FROM_DW));
  assign bus.p_done    = done_s & (l2_from_r == FROM_PF);

  assign bus.i_addrOK  = i_addrok_r;
  assign bus.d_addrOK  = d_addrok_r;
  assign bus.p_addrOK  = p_addrok_r;

  assign bus.l2_req    = l2_req_r;
  assign bus.l2_from   = l2_from_r;
  assign bus.l2_addr   = l2_addr_r;
  assign bus.l2_opcode = l2_opcode_r;
  assign bus.l2_wdata  = l2_wdata_r;
  assign bus.l2_wstrb  = l2_wstrb_r;
  assign bus.l2_size   = l2_size_r;

endmodule

// File: tb/tb_l2cache_req_arbiter.sv
// Testbench for l2cache_req_arbiter: directed scenarios followed by random
// request mixes, each transaction checked against a pending-request model
// that applies the grant priority rules. Honours L2ARB_STARVE_GUARD_EN.
module tb_l2cache_req_arbiter;
  localparam int STARVE_LIMIT = 8;
  localparam int AGE_MAX      = 15;
`ifdef L2ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int W_OP = 0, W_I = 1, W_DR = 2, W_DW = 3, W_PF = 4, W_NONE = 7;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  l2cache_req_arbiter_if bus ();
  l2cache_req_arbiter dut (.clk(clk), .rstn(rstn), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;

  // pending requests as seen by the requesters
  bit          op_pend, d_pend, d_wr_v, i_pend, p_pend, wb_busy_v;
  logic [31:0] op_a, op_c, d_a, d_wd, i_a, p_a, wb_a;
  logic [3:0]  d_st;
  logic [1:0]  d_sz;
  int          i_wait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] done_vec();
    return {bus.op_ack, bus.i_dataOK, bus.d_dataOK, bus.p_done};
  endfunction

  function automatic logic [2:0] ak_vec();
    return {bus.i_addrOK, bus.d_addrOK, bus.p_addrOK};
  endfunction

  function automatic logic [3:0] exp_done(input int w);
    case (w)
      W_OP:       return 4'b1000;
      W_I:        return 4'b0100;
      W_DR, W_DW: return 4'b0010;
      W_PF:       return 4'b0001;
      default:    return 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] exp_ak(input int w);
    case (w)
      W_I:        return 3'b100;
      W_DR, W_DW: return 3'b010;
      W_PF:       return 3'b001;
      default:    return 3'b000;
    endcase
  endfunction

  // Who wins given the pending set: op first; starved I next (guard build);
  // then D unless its write hits the line under writeback; then I; pref only
  // if no op, D or I request exists at all.
  function automatic int pick();
    bit blocked, starved;
    blocked = d_pend && d_wr_v && wb_busy_v && (d_a[31:5] == wb_a[31:5]);
    starved = GUARD && (i_wait >= STARVE_LIMIT);
    if (op_pend) return W_OP;
    if (i_pend && starved) return W_I;
    if (d_pend && !blocked) return d_wr_v ? W_DW : W_DR;
    if (i_pend) return W_I;
    if (p_pend && !d_pend) return W_PF;
    return W_NONE;
  endfunction

  task automatic drive_reqs();
    bus.op_req  = op_pend;  bus.op_addr = op_a;  bus.op_code = op_c;
    bus.d_req   = d_pend;   bus.d_wr    = d_wr_v; bus.d_addr = d_a;
    bus.d_wdata = d_wd;     bus.d_wstrb = d_st;  bus.d_size  = d_sz;
    bus.i_req   = i_pend;   bus.i_addr  = i_a;
    bus.p_req   = p_pend;   bus.p_addr  = p_a;
    bus.wb_busy = wb_busy_v; bus.wb_addr = wb_a;
  endtask

  // Advance one clock; the Icache wait count follows the age rule.
  task automatic adv(input bit grant_i);
    if (!bus.i_req || grant_i || !rstn) i_wait = 0;
    else if (i_wait < AGE_MAX) i_wait++;
    @(negedge clk);
    #1;
  endtask

  // Winner withdraws its request and scribbles on its inputs.
  task automatic retire(input int w);
    case (w)
      W_OP:       begin op_pend = 1'b0; op_a = $urandom; op_c = $urandom; end
      W_I:        begin i_pend = 1'b0; i_a = $urandom; end
      W_DR, W_DW: begin d_pend = 1'b0; d_a = $urandom; d_wd = $urandom; d_st = 4'($urandom_range(0, 15)); end
      W_PF:       begin p_pend = 1'b0; p_a = $urandom; end
      default:    begin end
    endcase
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_l2_req"},    32'(bus.l2_req),    32'd0);
    chk({tag, "_l2_from"},   32'(bus.l2_from),   32'd0);
    chk({tag, "_l2_addr"},   bus.l2_addr,        32'd0);
    chk({tag, "_l2_opcode"}, bus.l2_opcode,      32'd0);
    chk({tag, "_l2_wdata"},  bus.l2_wdata,       32'd0);
    chk({tag, "_l2_wstrb"},  32'(bus.l2_wstrb),  32'd0);
    chk({tag, "_l2_size"},   32'(bus.l2_size),   32'd0);
    chk({tag, "_addrok"},    32'(ak_vec()),      32'd0);
    chk({tag, "_done"},      32'(done_vec()),    32'd0);
  endtask

  // One arbitration slot starting in an IDLE cycle: k extra REQ cycles before
  // l2_addrOK, m extra RESP cycles before l2_dataOK. Returns in IDLE.
  task automatic do_txn(input int k, input int m, input bit hold);
    int w;
    logic [31:0] ea, eop, ewd;
    logic [3:0]  est;
    logic [1:0]  esz;
    bus.l2_addrOK = 1'b0;
    bus.l2_dataOK = 1'b0;
    drive_reqs();
    #1;
    w = pick();
    ea = 32'd0; eop = 32'd0; ewd = 32'd0; est = 4'd0; esz = 2'd2;
    case (w)
      W_OP:  begin ea = op_a; eop = op_c; end
      W_I:   ea = i_a;
      W_DR:  begin ea = d_a; esz = d_sz; end
      W_DW:  begin ea = d_a; esz = d_sz; ewd = d_wd; est = d_st; end
      W_PF:  ea = p_a;
      default: begin end
    endcase
    chk("idle_l2_req", 32'(bus.l2_req), 32'd0);
    chk("idle_done", 32'(done_vec()), 32'd0);
    adv(w == W_I);
    if (w == W_NONE) begin
      chk("no_grant_l2_req", 32'(bus.l2_req), 32'd0);
      chk("no_grant_addrok", 32'(ak_vec()), 32'd0);
      return;
    end
    chk("grant_l2_req", 32'(bus.l2_req), 32'd1);
    chk("grant_from", 32'(bus.l2_from), 32'(w));
    chk("grant_addr", bus.l2_addr, ea);
    chk("grant_opcode", bus.l2_opcode, eop);
    chk("grant_wstrb", 32'(bus.l2_wstrb), 32'(est));
    chk("grant_size", 32'(bus.l2_size), 32'(esz));
    if (w == W_DW) chk("grant_wdata", bus.l2_wdata, ewd);
    chk("grant_addrok", 32'(ak_vec()), 32'(exp_ak(w)));
    if (!hold) begin
      retire(w);
      drive_reqs();
    end
    for (int j = 0; j < k; j++) begin
      bus.l2_dataOK = 1'($urandom_range(0, 1));
      adv(1'b0);
      chk("req_l2_req_held", 32'(bus.l2_req), 32'd1);
      chk("req_addr_stable", bus.l2_addr, ea);
      chk("req_addrok_once", 32'(ak_vec()), 32'd0);
      chk("req_dataok_ignored", 32'(done_vec()), 32'd0);
    end
    bus.l2_dataOK = 1'b0;
    bus.l2_addrOK = 1'b1;
    adv(1'b0);
    bus.l2_addrOK = 1'b0;
    chk("resp_l2_req_low", 32'(bus.l2_req), 32'd0);
    for (int j = 0; j < m; j++) begin
      bus.l2_addrOK = 1'($urandom_range(0, 1));
      #1;
      chk("resp_wait_done", 32'(done_vec()), 32'd0);
      adv(1'b0);
      chk("resp_l2_req_stays_low", 32'(bus.l2_req), 32'd0);
    end
    bus.l2_addrOK = 1'b0;
    bus.l2_dataOK = 1'b1;
    #1;
    chk("done_onehot", 32'(done_vec()), 32'(exp_done(w)));
    adv(1'b0);
    bus.l2_dataOK = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    op_pend = 1'b0; d_pend = 1'b0; i_pend = 1'b0; p_pend = 1'b0; wb_busy_v = 1'b0;
    d_wr_v = 1'b0; op_a = 32'd0; op_c = 32'd0; d_a = 32'd0; d_wd = 32'd0;
    d_st = 4'd0; d_sz = 2'd0; i_a = 32'd0; p_a = 32'd0; wb_a = 32'd0; i_wait = 0;
    bus.l2_addrOK = 1'b0;
    bus.l2_dataOK = 1'b0;
    drive_reqs();
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;
    #1;

    // single Icache read
    i_pend = 1'b1; i_a = 32'h1C00_0040;
    do_txn(1, 2, 1'b0);

    // all four at once: op, D, I, pref in turn
    op_pend = 1'b1; op_a = 32'h0000_3000; op_c = 32'h0000_00A5;
    d_pend = 1'b1; d_wr_v = 1'b0; d_a = 32'h0000_4008; d_sz = 2'd1;
    i_pend = 1'b1; i_a = 32'h1C00_0080;
    p_pend = 1'b1; p_a = 32'h0000_5000;
    for (int t = 0; t < 4; t++) do_txn(0, 1, 1'b0);

    // Dcache write to the line under writeback
    wb_busy_v = 1'b1; wb_a = 32'h0000_1000;
    d_pend = 1'b1; d_wr_v = 1'b1; d_a = 32'h0000_1014; d_wd = 32'hDEAD_BEEF;
    d_st = 4'b0110; d_sz = 2'd2;
    i_pend = 1'b1; i_a = 32'h1C00_00C0;
    do_txn(0, 0, 1'b0);
    do_txn(0, 0, 1'b0);
    wb_busy_v = 1'b0;
    do_txn(1, 0, 1'b0);

    // Dcache held continuously alongside an Icache request
    d_pend = 1'b1; d_wr_v = 1'b0; d_a = 32'h0000_6000; d_sz = 2'd2;
    i_pend = 1'b1; i_a = 32'h1C00_0100;
    for (int t = 0; t < 5; t++) do_txn(1, 1, 1'b1);
    d_pend = 1'b0;
    do_txn(0, 0, 1'b0);
    i_pend = 1'b0;

    // reset while waiting for data
    d_pend = 1'b1; d_wr_v = 1'b0; d_a = 32'h0000_2000; d_sz = 2'd2;
    drive_reqs();
    #1;
    adv(1'b0);
    chk("rst_pre_from", 32'(bus.l2_from), 32'(W_DR));
    d_pend = 1'b0;
    drive_reqs();
    bus.l2_addrOK = 1'b1;
    adv(1'b0);
    bus.l2_addrOK = 1'b0;
    bus.l2_dataOK = 1'b1;
    rstn = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    adv(1'b0);
    chk("rst_held_no_d_dataok", 32'(bus.d_dataOK), 32'd0);
    bus.l2_dataOK = 1'b0;
    rstn = 1'b1;
    i_wait = 0;
    d_pend = 1'b1; d_a = 32'h0000_2040;
    do_txn(0, 1, 1'b0);

    // prefetch and Icache request rising together
    i_pend = 1'b1; i_a = 32'h1C00_0140;
    p_pend = 1'b1; p_a = 32'h0000_7000;
    do_txn(0, 0, 1'b0);
    do_txn(0, 0, 1'b0);

    // random request mixes
    for (int it = 0; it < 150; it++) begin
      if (!op_pend && $urandom_range(0, 4) == 0) begin
        op_pend = 1'b1; op_a = $urandom; op_c = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1'b1; d_wr_v = 1'($urandom_range(0, 1)); d_a = $urandom; d_wd = $urandom;
        d_st = 4'($urandom_range(1, 15)); d_sz = 2'($urandom_range(0, 2));
      end
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1'b1; i_a = $urandom;
      end
      if (!p_pend && $urandom_range(0, 1) == 0) begin
        p_pend = 1'b1; p_a = $urandom;
      end
      wb_busy_v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) wb_a = {d_a[31:5], 5'($urandom_range(0, 31))};
      else wb_a = $urandom;
      do_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
